// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - registered execute stage: operand select, ALU, data memory, flags
// One-deep output register behind a valid/ready handshake; flags are sticky.
module ex_stage_pipe #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic             memWrite,
  input  logic             memRead,
  input  logic             ALUSRC,
  input  logic [2:0]       ALUOP,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  output logic             valid_out,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] readData,
  output logic             zero,
  output logic             neg,
  output logic             addr_err
);

  localparam int ADDR_BITS = $clog2(MEM_DEPTH);

  logic [WIDTH-1:0]     mem [MEM_DEPTH];
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     alu_res;
  logic                 op_ok;
  logic                 accept;
  logic                 range_err;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] index;
  logic [WIDTH-1:0]     rd_data;

  assign in_ready  = !valid_out || out_ready;
  assign accept    = valid_in && in_ready;
  assign op_a      = ALUSRC ? imm : rd2;
  assign index     = rd1[ADDR_BITS-1:0];
  // Any bit above the index field means the address aliases outside the array.
  assign range_err = (rd1 >> ADDR_BITS) != '0;
  assign wr_en     = accept && memWrite && !range_err;

  always_comb begin
    alu_res = '0;
    op_ok   = 1'b1;
    unique case (ALUOP)
      3'b100:  alu_res = op_a + rd1;
      3'b010:  alu_res = ~rd1 + WIDTH'(1);
      3'b001:  alu_res = rd1 - op_a;
      3'b111:  alu_res = op_a;
      3'b110:  alu_res = op_a + WIDTH'(1);
      default: op_ok   = 1'b0;
    endcase
  end

  // Write-first: a same-beat write is forwarded to the read port.
  always_comb begin
    rd_data = '0;
    if (memRead && !range_err)
      rd_data = wr_en ? rd2 : mem[index];
  end

  always_ff @(posedge clock) begin
    if (reset_n && wr_en)
      mem[index] <= rd2;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      result    <= '0;
      readData  <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      addr_err  <= 1'b0;
    end else if (accept) begin
      valid_out <= 1'b1;
      result    <= alu_res;
      readData  <= rd_data;
      addr_err  <= range_err && (memRead || memWrite);
      if (op_ok) begin
        zero <= (alu_res == '0);
        neg  <= alu_res[WIDTH-1];
      end
    end else if (out_ready && valid_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised, registered execute stage: operand select, ALU (add/negate/subtract/pass/increment), synchronous data memory and flag generation.
- Sits between register-read/decode and writeback in the CPU pipeline.
- Adds a valid/ready handshake with a one-deep output register, so downstream stalls hold the stage without losing data.
- Adds sticky flags, out-of-range address detection and width/depth parameters.

Parameters:
WIDTH, 32, datapath width in bits (>=8)
MEM_DEPTH, 256, data memory words (power of two, >=4)
ADDR_BITS, log2(MEM_DEPTH), memory index bits (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
memWrite  in  1  write rd2 to mem[rd1]
memRead  in  1  read mem[rd1]
ALUSRC  in  1  ALU operand A: 1=imm, 0=rd2
ALUOP  in  3  {add,neg,sub} operation code
rd1  in  WIDTH  operand B and memory address
rd2  in  WIDTH  operand A (ALUSRC=0) and memory write data
imm  in  WIDTH  operand A (ALUSRC=1)
valid_out  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
result  out  WIDTH  registered ALU result
readData  out  WIDTH  registered memory read data
zero  out  1  sticky zero flag
neg  out  1  sticky negative flag
addr_err  out  1  current output beat had an out-of-range address

Behaviour:
- Reset (reset_n low, asynchronous):
  - valid_out=0, result=0, readData=0, zero=0, neg=0, addr_err=0.
  - Memory contents are not cleared; no write occurs while reset_n is low.
- Handshake:
  - in_ready = !valid_out || out_ready (combinational).
  - accept = valid_in && in_ready.
  - On a clock edge with accept: output registers load and valid_out=1.
  - Edge with out_ready && valid_out && !accept: valid_out=0; data outputs hold their last values.
  - Edge with neither: all outputs hold.
- Latency: 1 cycle from accept to valid_out; throughput 1 beat/cycle when out_ready stays high.
- Operands: A = ALUSRC ? imm : rd2; B = rd1. All arithmetic is modulo 2^WIDTH, two's complement.
- ALUOP decode:
  - 100: A+B
  - 010: -B (~B+1)
  - 001: B-A
  - 111: A (pass)
  - 110: A+1 (increment)
  - any other code: result=0, flags not updated.
- Flags: on accept with a decoded op, zero <= (result==0) and neg <= result[WIDTH-1]. Otherwise flags hold (sticky across memory-only and undefined ops).
- Memory: index = rd1[ADDR_BITS-1:0]; range error when rd1 >= MEM_DEPTH.
  - Write: on accept with memWrite && !range error, mem[index] <= rd2.
  - Read: on accept with memRead, readData <= range error ? 0 : mem[index].
  - Read and write to the same address in the same beat: write-first, so readData returns the new rd2.
  - memRead=0 on an accepted beat: readData <= 0.
  - addr_err <= range error && (memRead||memWrite) on every accepted beat.
- A beat with valid_in=0, or not accepted, performs no memory write and no flag update.
- Stall: while valid_out && !out_ready, no memory side effects for the held-off input. Upstream must hold its inputs.
- Reset mid-stall: the pending output beat is dropped; a write from an already-accepted beat persists.

Test Plan:
- Reset then ALUOP=100, ALUSRC=1, imm=7, rd1=5, valid_in=1, out_ready=1 -> next cycle valid_out=1, result=12, zero=0, neg=0.
- ALUOP=001, ALUSRC=0, rd2=9, rd1=4 -> result=0xFFFFFFFB, neg=1. Next beat memWrite only -> neg stays 1.
- Beat 1: memWrite, rd1=3, rd2=0xFFFFFFFC. Beat 2: memRead, rd1=3 -> readData=0xFFFFFFFC. Combined read+write to address 6 with rd2=20 -> readData=20.
- memWrite, rd1=300, rd2=1 -> addr_err=1, no write. Then memRead rd1=300 -> readData=0, addr_err=1. Then memRead rd1=44 -> original mem[44], addr_err=0.
- Hold out_ready=0 for 3 cycles with valid_in=1 -> in_ready=0, result held, no memory write. Release -> next beat accepted, result updates one cycle later.
- Pull reset_n low mid-stall with valid_out=1 -> valid_out, result, zero and neg are 0 immediately, memory retains earlier writes. WIDTH=16 run: ALUOP=010, rd1=1 -> result=0xFFFF.
